store_queue: RTL

//  Buffers store operands (address + data) produced by the mov/str datapath stage
//  and drains them in order to the data-memory write port.

---
 rtl/stq_pkg.sv | 22 ++
 rtl/stq_fwd_match.sv | 43 ++++
 rtl/store_queue.sv | 99 +++++++++
 3 files changed

// File: rtl/stq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stq_pkg
//  Description : Shared types and sizing constants for the store queue.
//  Revision    : 1.0  initial release
// ============================================================================
package stq_pkg;

   localparam int STQ_DATA_W = 32;
   localparam int STQ_ADDR_W = 32;
   localparam int STQ_DEPTH  = 4;

   localparam int PTR_W = $clog2(STQ_DEPTH);
   localparam int CNT_W = $clog2(STQ_DEPTH + 1);

   typedef struct packed {
      logic [STQ_ADDR_W-1:0] addr;
      logic [STQ_DATA_W-1:0] data;
   } stq_entry_t;

endpackage : stq_pkg
`default_nettype wire

// File: rtl/stq_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : stq_fwd_match
//  Description : Load-address search over occupied queue slots; returns the
//                youngest matching store's data.
//  Revision    : 1.0  initial release
// ============================================================================
module stq_fwd_match
   import stq_pkg::*;
#(
   parameter int DATA_W   = STQ_DATA_W,
   parameter int ADDR_W   = STQ_ADDR_W,
   parameter int DEPTH    = STQ_DEPTH,
   parameter int PTR_BITS = $clog2(DEPTH),
   parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
   input  logic [DEPTH-1:0][ADDR_W-1:0] addr_q,
   input  logic [DEPTH-1:0][DATA_W-1:0] data_q,
   input  logic [PTR_BITS-1:0]          rd_ptr,
   input  logic [CNT_BITS-1:0]          count,
   input  logic [ADDR_W-1:0]            ld_addr,
   output logic                         fwd_hit,
   output logic [DATA_W-1:0]            fwd_data
);

   logic [PTR_BITS-1:0] slot;

   // Walk oldest to youngest so the last match (youngest) wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      slot     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = rd_ptr + PTR_BITS'(k);
         if ((CNT_BITS'(k) < count) && (addr_q[slot] == ld_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[slot];
         end
      end
   end

endmodule : stq_fwd_match
`default_nettype wire

// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : store_queue
//  Description : In-order store buffer between mov/str and the data-memory
//                write port. Optional store-to-load forwarding: STQ_FWD_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module store_queue
   import stq_pkg::*;
#(
   parameter int DATA_W = STQ_DATA_W,
   parameter int ADDR_W = STQ_ADDR_W,
   parameter int DEPTH  = STQ_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ADDR_W-1:0]            in_addr,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         mem_valid,
   input  logic                         mem_ready,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
`ifdef STQ_FWD_EN
   input  logic [ADDR_W-1:0]            ld_addr,
   output logic                         fwd_hit,
   output logic [DATA_W-1:0]            fwd_data,
`endif
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
   logic [DEPTH-1:0][DATA_W-1:0] data_q;
   logic [PTR_BITS-1:0]          wr_ptr;
   logic [PTR_BITS-1:0]          rd_ptr;
   logic                         push;
   logic                         pop;

   // Status flags come only from the registered count, never from mem_ready.
   assign full      = (count == CNT_BITS'(DEPTH));
   assign empty     = (count == '0);
   assign in_ready  = !full;
   assign mem_valid = !empty;
   assign mem_addr  = addr_q[rd_ptr];
   assign mem_wdata = data_q[rd_ptr];

   assign push = in_valid && in_ready;
   assign pop  = mem_valid && mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         data_q <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

`ifdef STQ_FWD_EN
   stq_fwd_match #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .PTR_BITS (PTR_BITS),
      .CNT_BITS (CNT_BITS)
   ) u_fwd_match (
      .addr_q   (addr_q),
      .data_q   (data_q),
      .rd_ptr   (rd_ptr),
      .count    (count),
      .ld_addr  (ld_addr),
      .fwd_hit  (fwd_hit),
      .fwd_data (fwd_data)
   );
`endif

endmodule : store_queue
`default_nettype wire
